// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the V30MZ ALU and its issue sequencer.
//   - alu_op_e   : ALU operation codes (5-bit)
//   - alu_flag_e : bit positions of the 6-bit ALU flag vector
//   - is_shift_class / is_rotate / is_logic_op : op classification
//   - flag_we_mask : per-op PSW flag write mask table
//   - parity_even  : x86 parity of the low result byte
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 16;
  localparam int unsigned ALU_CNT_W  = 8;
  localparam int unsigned ALU_OP_W   = 5;
  localparam int unsigned ALU_FLAG_W = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_ADDC = 5'd1,
    OP_SUB  = 5'd2,
    OP_CMP  = 5'd3,
    OP_AND  = 5'd4,
    OP_OR   = 5'd5,
    OP_XOR  = 5'd6,
    OP_INC  = 5'd7,
    OP_DEC  = 5'd8,
    OP_NEG  = 5'd9,
    OP_ROL  = 5'd10,
    OP_ROR  = 5'd11,
    OP_ROLC = 5'd12,
    OP_RORC = 5'd13,
    OP_SHL  = 5'd14,
    OP_SHR  = 5'd15,
    OP_SHRA = 5'd16,
    OP_SHLA = 5'd17
  } alu_op_e;

  typedef enum logic [2:0] {
    FLAG_CY = 3'd0,
    FLAG_P  = 3'd1,
    FLAG_AC = 3'd2,
    FLAG_Z  = 3'd3,
    FLAG_S  = 3'd4,
    FLAG_V  = 3'd5
  } alu_flag_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RESP = 2'd2
  } seq_state_e;

  // Flag write masks, bit order as alu_flag_e.
  localparam logic [ALU_FLAG_W-1:0] FWE_ALL   = 6'b111111;
  localparam logic [ALU_FLAG_W-1:0] FWE_LOGIC = 6'b111011;  // no AC
  localparam logic [ALU_FLAG_W-1:0] FWE_INC   = 6'b111110;  // no CY
  localparam logic [ALU_FLAG_W-1:0] FWE_SHIFT = 6'b111011;  // CY V Z S P
  localparam logic [ALU_FLAG_W-1:0] FWE_ROT   = 6'b100001;  // CY V
  localparam logic [ALU_FLAG_W-1:0] FWE_NONE  = 6'b000000;

  function automatic logic is_shift_class(input logic [ALU_OP_W-1:0] op);
    case (op)
      OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_SHRA: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_rotate(input logic [ALU_OP_W-1:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  function automatic logic is_logic_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  function automatic logic [ALU_FLAG_W-1:0] flag_we_mask(input logic [ALU_OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_CMP:          return FWE_ALL;
      OP_AND, OP_OR, OP_XOR:           return FWE_LOGIC;
      OP_INC, OP_DEC:                  return FWE_INC;
      OP_SHL, OP_SHR, OP_SHRA:         return FWE_SHIFT;
      OP_ROL, OP_ROR:                  return FWE_ROT;
      default:                         return FWE_NONE;
    endcase
  endfunction

  function automatic logic parity_even(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational V30MZ ALU. Shifts and rotates move exactly one bit.
// Byte ops (size_i=0) operate on the low byte; the upper result byte is a_i[15:8].
// Ports:
//   op_i    : operation code (alu_op_e)
//   size_i  : 0=byte, 1=word
//   a_i,b_i : operands
//   r_o     : result
//   flags_o : flags in alu_flag_e bit order (all zero for unsupported ops)
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   op_i,
  input  logic                  size_i,
  input  logic [ALU_DATA_W-1:0] a_i,
  input  logic [ALU_DATA_W-1:0] b_i,
  output logic [ALU_DATA_W-1:0] r_o,
  output logic [ALU_FLAG_W-1:0] flags_o
);

  logic [16:0] am, bm, bx, sum;
  logic [15:0] res;
  logic [3:0]  msb;
  logic        cy, v, ac, sa, known;

  always_comb begin
    msb   = size_i ? 4'd15 : 4'd7;
    am    = size_i ? {1'b0, a_i} : {9'h000, a_i[7:0]};
    bm    = size_i ? {1'b0, b_i} : {9'h000, b_i[7:0]};
    bx    = ((op_i == OP_INC) || (op_i == OP_DEC)) ? 17'd1 : bm;
    sum   = '0;
    res   = a_i;
    cy    = 1'b0;
    v     = 1'b0;
    ac    = 1'b0;
    known = 1'b1;
    sa    = a_i[msb];
    case (op_i)
      OP_ADD, OP_INC: begin
        sum = am + bx;
        res = sum[15:0];
        cy  = size_i ? sum[16] : sum[8];
        ac  = am[4] ^ bx[4] ^ sum[4];
        v   = (sa == bx[msb]) && (res[msb] != sa);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        sum = am - bx;
        res = sum[15:0];
        cy  = size_i ? sum[16] : sum[8];
        ac  = am[4] ^ bx[4] ^ sum[4];
        v   = (sa != bx[msb]) && (res[msb] != sa);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_SHL: begin
        res = am[15:0] << 1;
        cy  = a_i[msb];
        v   = res[msb] ^ cy;
      end
      OP_SHR: begin
        res = am[15:0] >> 1;
        cy  = a_i[0];
        v   = a_i[msb];
      end
      OP_SHRA: begin
        res = (am[15:0] >> 1) | (16'(a_i[msb]) << msb);
        cy  = a_i[0];
      end
      OP_ROL: begin
        res = (am[15:0] << 1) | 16'(a_i[msb]);
        cy  = a_i[msb];
        v   = res[msb] ^ cy;
      end
      OP_ROR: begin
        res = (am[15:0] >> 1) | (16'(a_i[0]) << msb);
        cy  = a_i[0];
        v   = res[msb] ^ res[msb - 4'd1];
      end
      default: begin
        known = 1'b0;
        res   = a_i;
      end
    endcase

    r_o     = size_i ? res : {a_i[15:8], res[7:0]};
    flags_o = '0;
    if (known) begin
      flags_o[FLAG_CY] = cy;
      flags_o[FLAG_V]  = v;
      flags_o[FLAG_AC] = ac;
      flags_o[FLAG_Z]  = size_i ? (r_o == 16'h0000) : (r_o[7:0] == 8'h00);
      flags_o[FLAG_S]  = r_o[msb];
      flags_o[FLAG_P]  = parity_even(r_o[7:0]);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for the external combinational ALU.
// Accepts one request per valid/ready handshake, drives registered ALU inputs,
// decomposes multi-count shifts/rotates into single-bit steps and returns a
// registered result with per-flag PSW write enables.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready/req_op/req_size/req_a/req_b : request channel
//   alu_op/alu_size/alu_a/alu_b     : registered ALU inputs
//   alu_r/alu_flags                 : ALU result and flags
//   rsp_valid/rsp_ready             : response handshake
//   rsp_result/rsp_result_we/rsp_flags/rsp_flags_we : response payload
// Build option: ALU_SEQ_COUNT_MASK_EN masks the shift count to 5 bits.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned CNT_W  = ALU_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ALU_OP_W-1:0]   req_op,
  input  logic                  req_size,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  alu_size,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_r,
  input  logic [ALU_FLAG_W-1:0] alu_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_result_we,
  output logic [ALU_FLAG_W-1:0] rsp_flags,
  output logic [ALU_FLAG_W-1:0] rsp_flags_we
);

`ifdef ALU_SEQ_COUNT_MASK_EN
  localparam int unsigned CW = 5;
`else
  localparam int unsigned CW = CNT_W;
`endif

  seq_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
  logic                  alu_size_q, alu_size_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_result_q, rsp_result_d;
  logic                  rsp_result_we_q, rsp_result_we_d;
  logic [ALU_FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
  logic [ALU_FLAG_W-1:0] rsp_flags_we_q, rsp_flags_we_d;
  logic [CW-1:0]         req_cnt;
  logic [ALU_FLAG_W-1:0] fin_flags;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      req_ready_q     <= 1'b0;
      alu_op_q        <= '0;
      alu_size_q      <= 1'b0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_result_q    <= '0;
      rsp_result_we_q <= 1'b0;
      rsp_flags_q     <= '0;
      rsp_flags_we_q  <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      req_ready_q     <= req_ready_d;
      alu_op_q        <= alu_op_d;
      alu_size_q      <= alu_size_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_result_q    <= rsp_result_d;
      rsp_result_we_q <= rsp_result_we_d;
      rsp_flags_q     <= rsp_flags_d;
      rsp_flags_we_q  <= rsp_flags_we_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    alu_op_d        = alu_op_q;
    alu_size_d      = alu_size_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_result_d    = rsp_result_q;
    rsp_result_we_d = rsp_result_we_q;
    rsp_flags_d     = rsp_flags_q;
    rsp_flags_we_d  = rsp_flags_we_q;
    req_cnt         = req_b[CW-1:0];

    // Final flags: logic ops clear CY/V; shifts take Z/S/P from the final result.
    fin_flags = alu_flags;
    if (is_logic_op(alu_op_q)) begin
      fin_flags[FLAG_CY] = 1'b0;
      fin_flags[FLAG_V]  = 1'b0;
    end
    if (is_shift_class(alu_op_q) && !is_rotate(alu_op_q)) begin
      fin_flags[FLAG_Z] = alu_size_q ? (alu_r == '0) : (alu_r[7:0] == 8'h00);
      fin_flags[FLAG_S] = alu_size_q ? alu_r[DATA_W-1] : alu_r[7];
      fin_flags[FLAG_P] = parity_even(alu_r[7:0]);
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          alu_op_d   = req_op;
          alu_size_d = req_size;
          alu_a_d    = req_a;
          if (is_shift_class(req_op) && (req_cnt == '0)) begin
            // Zero-count shift: nothing to compute, result is A, no flag update.
            state_d         = S_RESP;
            rsp_valid_d     = 1'b1;
            rsp_result_d    = req_a;
            rsp_result_we_d = 1'b1;
            rsp_flags_d     = '0;
            rsp_flags_we_d  = '0;
          end else if (is_shift_class(req_op)) begin
            alu_b_d = DATA_W'(1);
            cnt_d   = req_cnt;
            state_d = S_STEP;
          end else begin
            alu_b_d = req_b;
            cnt_d   = CW'(1);
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q > CW'(1)) begin
          alu_a_d = alu_r;
          alu_b_d = DATA_W'(1);
        end else begin
          state_d         = S_RESP;
          rsp_valid_d     = 1'b1;
          rsp_result_d    = alu_r;
          rsp_result_we_d = (alu_op_q != OP_CMP);
          rsp_flags_d     = fin_flags;
          rsp_flags_we_d  = flag_we_mask(alu_op_q);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  assign req_ready     = req_ready_q;
  assign alu_op        = alu_op_q;
  assign alu_size      = alu_size_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_result_we = rsp_result_we_q;
  assign rsp_flags     = rsp_flags_q;
  assign rsp_flags_we  = rsp_flags_we_q;

endmodule
